// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and sizing for the sequential multiplier
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/fastAdder32.sv
// rtl/fastAdder32.sv - 32-bit adder with carry in/out, the single adder shared by every step
module fastAdder32
  import mul_pkg::*;
(
  input  logic                 cin,
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  output logic [MUL_WIDTH-1:0] sum,
  output logic                 cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{MUL_WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_mul32_ctrl.sv
// rtl/seq_mul32_ctrl.sv - shift-add unsigned 32x32 multiplier, one step per clock
module seq_mul32_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  mul_state_t           state_q, state_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     breg_q, breg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     product_q, product_d;
  logic                 overflow_q, overflow_d;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [2*WIDTH-1:0]   p_step;

  assign add_b = p_q[0] ? breg_q : '0;

  fastAdder32 u_adder (
    .cin  (1'b0),
    .a    (p_q[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Carry-out becomes the new MSB so partial sums >= 2^32 are not lost.
  assign p_step = {add_cout, add_sum, p_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    breg_d     = breg_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          p_d     = {{WIDTH{1'b0}}, a};
          breg_d  = b;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          p_d   = p_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
            state_d    = S_DONE;
            product_d  = p_step[WIDTH-1:0];
            overflow_d = |p_step[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      breg_q     <= '0;
      cnt_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      breg_q     <= breg_d;
      cnt_q      <= cnt_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_mul32_ctrl.sv
// tb/tb_seq_mul32_ctrl.sv - scoreboard bench for the sequential multiplier
module tb_seq_mul32_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        overflow;

  int          checks;
  int          errors;
  logic [32:0] exp_q[$];
  logic [31:0] last_prod;
  logic        last_ovf;

  seq_mul32_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a multiply; the expected {overflow, product} is computed here and queued.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input bit push);
    logic [63:0] full;
    full  = {32'h0, av} * {32'h0, bv};
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) exp_q.push_back({(full[63:32] != 32'h0), full[31:0]});
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic check_result(input string name);
    logic [32:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: done with empty scoreboard", name);
    end else begin
      e = exp_q.pop_front();
      last_prod = e[31:0];
      last_ovf  = e[32];
      if (product !== e[31:0] || overflow !== e[32]) begin
        errors++;
        $display("FAIL %s: got product=%h ovf=%b need product=%h ovf=%b",
                 name, product, overflow, e[31:0], e[32]);
      end
    end
  endtask

  // Called right after issue(): expects busy for 32 samples then a single done pulse.
  task automatic wait_done(input string name);
    int cyc;
    int busy_cnt;
    cyc = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 32 || busy_cnt != 32) begin
      errors++;
      $display("FAIL %s_latency: got cycles=%0d busy=%0d need 32/32", name, cyc, busy_cnt);
    end
    if (done === 1'b1) check_result(name);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: got done=%b busy=%b need 0/0", name, done, busy);
    end
  endtask

  task automatic expect_quiet(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s_quiet: got %0d active cycles need 0", name, seen);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b product=%h ovf=%b need 0", busy, done, product, overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    issue(32'd3, 32'd5, 1'b1);
    wait_done("mul_3x5");
  endtask

  task automatic test_overflow();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("mul_max");
    issue(32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_done("mul_2p32");
    issue(32'h0000_FFFF, 32'h0001_0001, 1'b1);
    wait_done("mul_just_under");
  endtask

  task automatic test_edges();
    issue(32'h8000_0000, 32'd1, 1'b1);
    wait_done("mul_msb");
    issue(32'd0, 32'hDEAD_BEEF, 1'b1);
    wait_done("mul_zero");
    for (int i = 0; i < 3; i++) begin
      issue($urandom, $urandom, 1'b1);
      wait_done("mul_rand");
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    issue(32'h1234_5678, 32'h0000_0ABC, 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 5 || cyc == 20) begin
        a = $urandom;
        b = $urandom;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    checks++;
    if (cyc != 32) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d need 32", cyc);
    end
    if (done === 1'b1) check_result("busy_start");
    tick();
    expect_quiet("busy_start", 40);
  endtask

  task automatic test_abort(input bit with_start);
    issue(32'h0BAD_F00D, 32'h0000_1111, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    abort = 1'b1;
    start = with_start;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b need 0/0", busy, done);
    end
    expect_quiet("abort", 40);
    checks++;
    if (product !== last_prod || overflow !== last_ovf) begin
      errors++;
      $display("FAIL abort_hold: got product=%h ovf=%b need %h/%b", product, overflow, last_prod, last_ovf);
    end
  endtask

  task automatic test_async_reset();
    issue(32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b product=%h ovf=%b need 0", busy, done, product, overflow);
    end
    tick();
    rst_n = 1'b1;
    expect_quiet("post_reset", 40);
    issue(32'd7, 32'd6, 1'b1);
    wait_done("mul_7x6");
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(32'h0000_ABCD, 32'h0001_2345, 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    if (done === 1'b1) check_result("b2b_first");
    issue(32'hCAFE_0001, 32'h0000_0003, 1'b1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d need 33", cyc);
    end
    if (done === 1'b1) check_result("b2b_second");
    tick();
    expect_quiet("b2b", 5);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_prod = 32'h0;
    last_ovf  = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a = 32'h0;
    b = 32'h0;
    test_reset();
    test_basic();
    test_overflow();
    test_edges();
    test_start_while_busy();
    test_abort(1'b0);
    test_abort(1'b1);
    test_async_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
